// File: rtl/pipe_stage_elastic.sv
// rtl/pipe_stage_elastic.sv - elastic valid/ready pipeline stage register with flush and stall counter
// Define PIPE_SKID_EN for a 2-entry main+skid buffer whose in_ready is registered.
module pipe_stage_elastic #(
   parameter int                DATA_W = 128,
   parameter logic [DATA_W-1:0] BUBBLE = '0,
   parameter int                CNT_W  = 16
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   input  logic              flush,
   output logic [1:0]        occupancy,
   output logic [CNT_W-1:0]  stall_cnt
);

`ifdef PIPE_SKID_EN
   typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;
   logic [DATA_W-1:0] skid_q, skid_n;
`else
   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;
`endif

   state_t            state, state_n;
   logic [DATA_W-1:0] main_q, main_n;
   logic              accept, issue;

   // main_q holds BUBBLE whenever the stage is empty, so out_data needs no mux
   assign out_data  = main_q;
   assign out_valid = (state != EMPTY);
   assign issue     = out_valid && out_ready;
   assign accept    = in_valid && in_ready;

`ifdef PIPE_SKID_EN
   assign in_ready = flush || (state != TWO);

   always_comb begin
      state_n   = state;
      main_n    = main_q;
      skid_n    = skid_q;
      occupancy = 2'd0;
      case (state)
         ONE:     occupancy = 2'd1;
         TWO:     occupancy = 2'd2;
         default: occupancy = 2'd0;
      endcase
      if (flush) begin
         state_n = EMPTY;
         main_n  = BUBBLE;
         skid_n  = BUBBLE;
      end else begin
         case (state)
            EMPTY: if (accept) begin
               state_n = ONE;
               main_n  = in_data;
            end
            ONE: if (accept && issue) begin
               main_n = in_data;
            end else if (accept) begin
               state_n = TWO;
               skid_n  = in_data;
            end else if (issue) begin
               state_n = EMPTY;
               main_n  = BUBBLE;
            end
            TWO: if (issue) begin
               state_n = ONE;
               main_n  = skid_q;
               skid_n  = BUBBLE;
            end
            default: begin
               state_n = EMPTY;
               main_n  = BUBBLE;
               skid_n  = BUBBLE;
            end
         endcase
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) skid_q <= BUBBLE;
      else       skid_q <= skid_n;
   end
`else
   assign in_ready = flush || (state != FULL) || out_ready;

   always_comb begin
      state_n   = state;
      main_n    = main_q;
      occupancy = {1'b0, state == FULL};
      if (flush) begin
         state_n = EMPTY;
         main_n  = BUBBLE;
      end else begin
         case (state)
            EMPTY: if (accept) begin
               state_n = FULL;
               main_n  = in_data;
            end
            // accept while FULL implies issue, so this is a replace at full throughput
            FULL: if (accept) begin
               main_n = in_data;
            end else if (issue) begin
               state_n = EMPTY;
               main_n  = BUBBLE;
            end
            default: begin
               state_n = EMPTY;
               main_n  = BUBBLE;
            end
         endcase
      end
   end
`endif

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state  <= EMPTY;
         main_q <= BUBBLE;
      end else begin
         state  <= state_n;
         main_q <= main_n;
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST)
         stall_cnt <= '0;
      else if (out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}}))
         stall_cnt <= stall_cnt + CNT_W'(1);
   end

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// tb/tb_pipe_stage_elastic.sv - queue-model bench for pipe_stage_elastic
// Honours PIPE_SKID_EN to select the matching capacity/in_ready rule.
module tb_pipe_stage_elastic;
   localparam int          DW  = 16;
   localparam logic [15:0] BUB = 16'hB0B0;
   localparam int          CW  = 4;
   localparam int          SMAX = (1 << CW) - 1;

   logic          CLK, nRST;
   logic          in_valid, in_ready, out_valid, out_ready, flush;
   logic [DW-1:0] in_data, out_data;
   logic [1:0]    occupancy;
   logic [CW-1:0] stall_cnt;

   int total = 0;
   int bad   = 0;

   pipe_stage_elastic #(.DATA_W(DW), .BUBBLE(BUB), .CNT_W(CW)) dut (
      .CLK(CLK), .nRST(nRST),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .flush(flush), .occupancy(occupancy), .stall_cnt(stall_cnt)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: FIFO of held bundles, capacity 1 (or 2 with skid)
   logic [DW-1:0] q[$];
   int            stall_m;

   function automatic logic exp_ready();
`ifdef PIPE_SKID_EN
      return flush || (q.size() < 2);
`else
      return flush || (q.size() == 0) || out_ready;
`endif
   endfunction

   always @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         q.delete();
         stall_m = 0;
      end else begin
         logic v, iss, acc;
         v   = (q.size() != 0);
         iss = v && out_ready;
         acc = in_valid && exp_ready();
         if (v && !out_ready && stall_m < SMAX) stall_m++;
         if (flush) q.delete();
         else begin
            if (iss) void'(q.pop_front());
            if (acc) q.push_back(in_data);
         end
      end
   end

   always @(negedge CLK) begin
      check("out_valid", 32'(out_valid), 32'(q.size() != 0));
      check("out_data", 32'(out_data), (q.size() != 0) ? 32'(q[0]) : 32'(BUB));
      check("occupancy", 32'(occupancy), 32'(q.size()));
      check("in_ready", 32'(in_ready), 32'(exp_ready()));
      check("stall_cnt", 32'(stall_cnt), 32'(stall_m));
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic do_reset();
      nRST = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; in_data = '0;
      #1;
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_data", 32'(out_data), 32'(BUB));
      check("rst_stall", 32'(stall_cnt), 32'd0);
      check("rst_ready", 32'(in_ready), 32'd1);
      tick();
      nRST = 1'b1;
   endtask

   initial begin
      nRST = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; in_data = '0;
      tick();
      do_reset();

      // streaming 1..8 at full throughput
      in_valid = 1'b1; out_ready = 1'b1; in_data = 16'd1;
      for (int k = 1; k <= 8; k++) begin
         tick();
         check("stream_data", 32'(out_data), 32'(k));
         check("stream_valid", 32'(out_valid), 32'd1);
         in_data = 16'(k + 1);
      end
      in_valid = 1'b0;
      tick();
      check("stream_drain", 32'(out_valid), 32'd0);

      // backpressure
      do_reset();
      in_valid = 1'b1; in_data = 16'h00A5; out_ready = 1'b0;
      tick();
      check("bp_first", 32'(out_data), 32'h00A5);
`ifdef PIPE_SKID_EN
      check("bp_ready1", 32'(in_ready), 32'd1);
`else
      check("bp_ready1", 32'(in_ready), 32'd0);
`endif
      in_data = 16'h005A;
      for (int k = 0; k < 5; k++) begin
         tick();
         check("bp_hold", 32'(out_data), 32'h00A5);
         check("bp_ready", 32'(in_ready), 32'd0);
      end
      check("bp_stall5", 32'(stall_cnt), 32'd5);
`ifdef PIPE_SKID_EN
      check("bp_occ2", 32'(occupancy), 32'd2);
`else
      check("bp_occ1", 32'(occupancy), 32'd1);
`endif
      out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      check("bp_second", 32'(out_data), 32'h005A);
      tick();
      check("bp_empty", 32'(out_data), 32'(BUB));

      // flush with a valid incoming bundle
      do_reset();
      in_valid = 1'b1; in_data = 16'h0011;
      tick();
      in_data = 16'h0022;
      tick();
      flush = 1'b1; in_data = 16'h0033;
      #1;
      check("flush_ready", 32'(in_ready), 32'd1);
      tick();
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      check("flush_valid", 32'(out_valid), 32'd0);
      check("flush_occ", 32'(occupancy), 32'd0);
      check("flush_data", 32'(out_data), 32'(BUB));
      for (int k = 0; k < 3; k++) begin
         tick();
         check("flush_gone", 32'(out_valid), 32'd0);
      end

      // saturation
      do_reset();
      in_valid = 1'b1; in_data = 16'h0077;
      tick();
      in_valid = 1'b0;
      for (int k = 0; k < 20; k++) tick();
      check("sat_cnt", 32'(stall_cnt), 32'd15);

      // reset while FULL and stalled takes effect immediately
      #2;
      nRST = 1'b0;
      #1;
      check("midrst_valid", 32'(out_valid), 32'd0);
      check("midrst_data", 32'(out_data), 32'(BUB));
      check("midrst_stall", 32'(stall_cnt), 32'd0);
      check("midrst_occ", 32'(occupancy), 32'd0);
      tick();
      nRST = 1'b1;

`ifdef PIPE_SKID_EN
      // in_ready must not follow out_ready between edges
      for (int k = 0; k < 16; k++) begin
         logic r;
         in_valid = 1'($urandom_range(0, 1)); in_data = 16'($urandom);
         tick();
         r = in_ready;
         out_ready = ~out_ready;
         #1;
         check("skid_reg_ready", 32'(in_ready), 32'(r));
      end
`endif

      // randomized traffic against the queue model
      for (int k = 0; k < 600; k++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         flush     = ($urandom_range(0, 15) == 0);
         in_data   = 16'($urandom);
         tick();
      end
      in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
      tick(); tick(); tick();
      @(negedge CLK);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
